usbh_nes_joypad_port: RTL and testbench

- Sequences decoded USB joystick button bytes from two upstream report decoders into the NES serial joypad protocol: strobe/latch, then bit-serial reads for ports $4016/$4017.
- Holds the last valid report per port.
- A watchdog clears buttons when a joystick stops reporting.
- Sits between the USB host report decoders (USB clock domain) and the NES CPU bus glue, which must already be synchronised to i_clk.

---
 rtl/usbh_nes_pkg.sv | 23 ++
 rtl/usbh_nes_joypad_lane.sv | 73 +++++++
 rtl/usbh_nes_joypad_port.sv | 83 ++++++++
 tb/tb_usbh_nes_joypad_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/usbh_nes_pkg.sv
// rtl/usbh_nes_pkg.sv - shared button indices, lane state and timeout helper for NES USB blocks
package usbh_nes_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic {
    STALE = 1'b0,
    LIVE  = 1'b1
  } lane_state_e;

  // Number of clock cycles in the report-silence window.
  function automatic int timeout_cycles(input int clk_hz, input int timeout_ms);
    return (clk_hz / 1000) * timeout_ms;
  endfunction

endpackage

// File: rtl/usbh_nes_joypad_lane.sv
// rtl/usbh_nes_joypad_lane.sv - one joypad port: held report, watchdog, STALE/LIVE FSM, serial shifter
module usbh_nes_joypad_lane
  import usbh_nes_pkg::*;
#(
  parameter int c_timeout_cycles = 600000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn,
  input  logic       btn_valid,
  input  logic       strobe,
  input  logic       rd,
  input  logic       mask_ba,
  output logic       data,
  output logic       stale
);

  localparam int c_wd_max = c_timeout_cycles - 1;
  localparam int c_wd_w   = (c_wd_max < 1) ? 1 : $clog2(c_wd_max + 1);

  lane_state_e       state;
  lane_state_e       state_nxt;
  logic [7:0]        btn_q;
  logic [7:0]        shift;
  logic [7:0]        load;
  logic [c_wd_w-1:0] wd;
  logic              timeout;

  assign timeout = (wd == c_wd_w'(c_wd_max));
  assign load    = mask_ba ? {btn_q[7:2], 2'b00} : btn_q;

  always_comb begin
    state_nxt = state;
    if (btn_valid) begin
      state_nxt = LIVE;
    end else if (state == LIVE && timeout) begin
      state_nxt = STALE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STALE;
      btn_q <= 8'h00;
      wd    <= '0;
      shift <= 8'h00;
    end else begin
      state <= state_nxt;
      // A fresh report always beats a timeout landing in the same cycle.
      if (btn_valid) begin
        btn_q <= btn;
        wd    <= '0;
      end else if (state == LIVE) begin
        if (timeout) begin
          btn_q <= 8'h00;
          wd    <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
      end
      // Ones fill from the top so reads past the eighth return 1.
      if (strobe) begin
        shift <= load;
      end else if (rd) begin
        shift <= {1'b1, shift[7:1]};
      end
    end
  end

  assign data  = shift[BTN_A];
  assign stale = (state == STALE);

endmodule

// File: rtl/usbh_nes_joypad_port.sv
// rtl/usbh_nes_joypad_port.sv - two-port NES serial joypad front end; optional autofire via USBH_JOYPAD_AUTOFIRE_EN
module usbh_nes_joypad_port
  import usbh_nes_pkg::*;
#(
  parameter int c_clk_hz      = 6000000,
  parameter int c_timeout_ms  = 100,
  parameter int c_autofire_hz = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_btn0,
  input  logic       i_btn0_valid,
  input  logic [7:0] i_btn1,
  input  logic       i_btn1_valid,
  input  logic       i_strobe,
  input  logic       i_rd0,
  input  logic       i_rd1,
  input  logic [1:0] i_turbo,
  output logic       o_data0,
  output logic       o_data1,
  output logic [1:0] o_stale
);

  localparam int c_timeout_cycles = timeout_cycles(c_clk_hz, c_timeout_ms);

  logic [1:0] mask_ba;

`ifdef USBH_JOYPAD_AUTOFIRE_EN
  localparam int c_af_div = c_clk_hz / (2 * c_autofire_hz);
  localparam int c_af_w   = (c_af_div < 2) ? 1 : $clog2(c_af_div);

  logic [c_af_w-1:0] af_cnt;
  logic              phase;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == c_af_w'(c_af_div - 1)) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  // A and B are released during the low half of the autofire square wave.
  assign mask_ba = i_turbo & {2{~phase}};
`else
  logic unused_turbo;
  assign unused_turbo = ^i_turbo;
  assign mask_ba      = 2'b00;
`endif

  usbh_nes_joypad_lane #(
    .c_timeout_cycles(c_timeout_cycles)
  ) u_lane0 (
    .clk      (i_clk),
    .reset    (i_reset),
    .btn      (i_btn0),
    .btn_valid(i_btn0_valid),
    .strobe   (i_strobe),
    .rd       (i_rd0),
    .mask_ba  (mask_ba[0]),
    .data     (o_data0),
    .stale    (o_stale[0])
  );

  usbh_nes_joypad_lane #(
    .c_timeout_cycles(c_timeout_cycles)
  ) u_lane1 (
    .clk      (i_clk),
    .reset    (i_reset),
    .btn      (i_btn1),
    .btn_valid(i_btn1_valid),
    .strobe   (i_strobe),
    .rd       (i_rd1),
    .mask_ba  (mask_ba[1]),
    .data     (o_data1),
    .stale    (o_stale[1])
  );

endmodule

// File: tb/tb_usbh_nes_joypad_port.sv
// tb/tb_usbh_nes_joypad_port.sv - directed self-checking bench for usbh_nes_joypad_port
module tb_usbh_nes_joypad_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn0 = 8'h00;
  logic       btn0_valid = 1'b0;
  logic [7:0] btn1 = 8'h00;
  logic       btn1_valid = 1'b0;
  logic       strobe = 1'b0;
  logic       rd0 = 1'b0;
  logic       rd1 = 1'b0;
  logic [1:0] turbo = 2'b00;
  logic       data0;
  logic       data1;
  logic [1:0] stale;

  int n_checks = 0;
  int n_pass = 0;

  usbh_nes_joypad_port #(
    .c_clk_hz     (6000000),
    .c_timeout_ms (1),
    .c_autofire_hz(1000)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_btn0      (btn0),
    .i_btn0_valid(btn0_valid),
    .i_btn1      (btn1),
    .i_btn1_valid(btn1_valid),
    .i_strobe    (strobe),
    .i_rd0       (rd0),
    .i_rd1       (rd1),
    .i_turbo     (turbo),
    .o_data0     (data0),
    .o_data1     (data1),
    .o_stale     (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] b);
    btn0 = b; btn0_valid = 1'b1; tick(1); btn0_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    btn1 = b; btn1_valid = 1'b1; tick(1); btn1_valid = 1'b0;
  endtask

  task automatic strobe_pulse();
    strobe = 1'b1; tick(1); strobe = 1'b0;
  endtask

  // Checks n bits on port 0 (LSB of exp first), issuing one read after each sample.
  task automatic read0(input string tag, input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {31'b0, data0}, {31'b0, exp[i]});
      rd0 = 1'b1; tick(1); rd0 = 1'b0;
    end
  endtask

  task automatic read1(input string tag, input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), {31'b0, data1}, {31'b0, exp[i]});
      rd1 = 1'b1; tick(1); rd1 = 1'b0;
    end
  endtask

  initial begin
    tick(3);
    check("reset_stale", {30'b0, stale}, 32'h3);
    check("reset_data0", {31'b0, data0}, 32'h0);
    check("reset_data1", {31'b0, data1}, 32'h0);
    reset = 1'b0;

`ifdef USBH_JOYPAD_AUTOFIRE_EN
    // Phase 0 for the first 3000 cycles after reset: port 0 A/B masked.
    turbo = 2'b01;
    send0(8'h03); send1(8'h03);
    strobe_pulse();
    read0("af_ph0_p0", 2, 16'h0000);
    read1("af_ph0_p1", 2, 16'h0003);
    tick(3000);
    send0(8'h03); send1(8'h03);
    strobe_pulse();
    read0("af_ph1_p0", 2, 16'h0003);
    read1("af_ph1_p1", 2, 16'h0003);
    tick(2990);
    send0(8'h03); send1(8'h03);
    strobe_pulse();
    read0("af_ph0b_p0", 2, 16'h0000);
    read1("af_ph0b_p1", 2, 16'h0003);
    turbo = 2'b00;
`else
    turbo = 2'b11;
    send0(8'h03); send1(8'h03);
    strobe_pulse();
    read0("noaf_p0", 2, 16'h0003);
    read1("noaf_p1", 2, 16'h0003);
    turbo = 2'b00;
`endif

    reset = 1'b1; tick(1); reset = 1'b0;

    // Empty ports read all zeros for the eight buttons.
    strobe_pulse();
    read0("empty", 8, 16'h0000);
    check("empty_stale", {30'b0, stale}, 32'h3);

    // 0x81: A and Right pressed, then open-bus 1.
    send0(8'h81);
    strobe_pulse();
    read0("b81", 9, 16'h0181);
    check("b81_stale", {30'b0, stale}, 32'h2);
    check("b81_p1", {31'b0, data1}, 32'h0);

    // Reads while strobe is held keep reloading A.
    send0(8'h02);
    strobe = 1'b1; tick(1);
    for (int i = 0; i < 3; i++) begin
      rd0 = 1'b1; tick(1); rd0 = 1'b0;
      check($sformatf("hold_a%0d", i), {31'b0, data0}, 32'h0);
    end
    strobe = 1'b0;
    read0("hold_release", 2, 16'h0002);

    // Mid-sequence report only updates the held byte.
    send0(8'hF0);
    strobe_pulse();
    read0("mid_old", 3, 16'h0000);
    send0(8'h01);
    read0("mid_rest", 6, 16'h003E);
    strobe_pulse();
    read0("mid_new", 2, 16'h0001);

    // Port 1 independent: Left pressed.
    send1(8'h40);
    strobe_pulse();
    read1("p1_left", 8, 16'h0040);

    // Watchdog: stale exactly 6000 cycles after the last report.
    send0(8'hFF);
    tick(5999);
    check("wd_live_5999", {31'b0, stale[0]}, 32'h0);
    tick(1);
    check("wd_stale_6000", {31'b0, stale[0]}, 32'h1);
    strobe_pulse();
    read0("wd_cleared", 2, 16'h0000);

    // A report arriving on the last live cycle keeps the port live.
    send0(8'hFF);
    tick(5998);
    send0(8'hFF);
    tick(1);
    check("wd_refresh", {31'b0, stale[0]}, 32'h0);
    check("wd_p1_stale", {31'b0, stale[1]}, 32'h1);

    // Reset in the middle of a read sequence.
    send0(8'hFF);
    strobe_pulse();
    read0("pre_rst", 2, 16'h0003);
    reset = 1'b1; tick(1);
    check("rst_mid_stale", {30'b0, stale}, 32'h3);
    check("rst_mid_data", {31'b0, data0}, 32'h0);
    reset = 1'b0;
    strobe_pulse();
    read0("post_rst", 2, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
